// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-file constants and default timeout.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0           = 5'd0;
    localparam int         DEFAULT_MAX_WAIT = 16;

    // True when a load in EX writes a register that the instruction in ID reads.
    function automatic logic load_use_hit(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return memread && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         start_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// flushes, data-memory freeze with timeout, and saturating statistics.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RDaddr_i,
    input  logic             Branch_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             IFID_stall_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             pipe_stall_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [1:0]       dbg_state_o
);

    localparam int WC_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_nxt;
    logic            memstall;
    logic            loaduse;

    // Memory handshake: mem_req_i is raised by MEM and held until the cycle in
    // which mem_ack_i is high; that ack cycle completes the access and is not
    // itself a stall cycle. A request is only sampled while in RUN.
    assign memstall = ((state == ST_RUN) && mem_req_i && !mem_ack_i) ||
                      ((state == ST_MEM_WAIT) && !mem_ack_i);
    assign loaduse  = load_use_hit(IDEX_MemRead_i, IDEX_RDaddr_i, RS1addr_i, RS2addr_i);

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            ST_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = WC_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_ERR;
                end else begin
                    wait_nxt = wait_cnt + WC_W'(1);
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Priority: ERR > memstall > load-use > branch; a branch resolved against
    // stale operands during a load-use is dropped and retried next cycle.
    always_comb begin
        PCWrite_o     = 1'b0;
        IFID_stall_o  = 1'b0;
        IFID_flush_o  = 1'b0;
        IDEX_bubble_o = 1'b0;
        pipe_stall_o  = 1'b0;
        if (start_i) begin
            if ((state == ST_ERR) || memstall) begin
                IFID_stall_o = 1'b1;
                pipe_stall_o = 1'b1;
            end else if (loaduse) begin
                IFID_stall_o  = 1'b1;
                IDEX_bubble_o = 1'b1;
            end else if (Branch_i) begin
                PCWrite_o    = 1'b1;
                IFID_flush_o = 1'b1;
            end else begin
                PCWrite_o = 1'b1;
            end
        end
    end

    assign err_o       = (state == ST_ERR);
    assign dbg_state_o = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .start_i (start_i),
        .inc_i   (!PCWrite_o),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .start_i (start_i),
        .inc_i   (IFID_flush_o),
        .cnt_o   (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MAX_WAIT=4 and CNT_W=3.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 3;

    // control vector order: {PCWrite, IFID_stall, IFID_flush, IDEX_bubble, pipe_stall}
    localparam logic [4:0] C_OFF   = 5'b00000;
    localparam logic [4:0] C_RUN   = 5'b10000;
    localparam logic [4:0] C_FRZ   = 5'b01001;
    localparam logic [4:0] C_LU    = 5'b01010;
    localparam logic [4:0] C_BR    = 5'b10100;

    logic             clk_i = 1'b0;
    logic             start_i;
    logic [4:0]       RS1addr_i, RS2addr_i, IDEX_RDaddr_i;
    logic             IDEX_MemRead_i, Branch_i, mem_req_i, mem_ack_i;
    logic             PCWrite_o, IFID_stall_o, IFID_flush_o, IDEX_bubble_o, pipe_stall_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
    logic [1:0]       dbg_state_o;
    logic [4:0]       ctrl;

    int n_cmp = 0;
    int n_err = 0;

    assign ctrl = {PCWrite_o, IFID_stall_o, IFID_flush_o, IDEX_bubble_o, pipe_stall_o};

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .start_i        (start_i),
        .RS1addr_i      (RS1addr_i),
        .RS2addr_i      (RS2addr_i),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_RDaddr_i  (IDEX_RDaddr_i),
        .Branch_i       (Branch_i),
        .mem_req_i      (mem_req_i),
        .mem_ack_i      (mem_ack_i),
        .PCWrite_o      (PCWrite_o),
        .IFID_stall_o   (IFID_stall_o),
        .IFID_flush_o   (IFID_flush_o),
        .IDEX_bubble_o  (IDEX_bubble_o),
        .pipe_stall_o   (pipe_stall_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .dbg_state_o    (dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic clear_inputs();
        RS1addr_i      = 5'd0;
        RS2addr_i      = 5'd0;
        IDEX_RDaddr_i  = 5'd0;
        IDEX_MemRead_i = 1'b0;
        Branch_i       = 1'b0;
        mem_req_i      = 1'b0;
        mem_ack_i      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic pulse_reset();
        start_i = 1'b0;
        #1;
        start_i = 1'b1;
        #1;
    endtask

    task automatic set_loaduse(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        IDEX_MemRead_i = 1'b1;
        IDEX_RDaddr_i  = rd;
        RS1addr_i      = rs1;
        RS2addr_i      = rs2;
    endtask

    initial begin
        clear_inputs();
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        check("reset_ctrl", 32'(ctrl), 32'(C_OFF));
        check("reset_err", 32'(err_o), 0);
        check("reset_stall_cnt", 32'(stall_cnt_o), 0);
        start_i = 1'b1;
        #1;
        check("idle_ctrl", 32'(ctrl), 32'(C_RUN));
        check("idle_state", 32'(dbg_state_o), 0);
        check("idle_flush_cnt", 32'(flush_cnt_o), 0);

        // load-use on rs2 with a simultaneous branch
        set_loaduse(5'd5, 5'd0, 5'd5);
        Branch_i = 1'b1;
        #1;
        check("lu_ctrl", 32'(ctrl), 32'(C_LU));
        step();
        clear_inputs();
        check("lu_stall_cnt", 32'(stall_cnt_o), 1);
        check("lu_flush_cnt", 32'(flush_cnt_o), 0);

        // rd = x0 is never a hazard, so the branch goes through
        set_loaduse(5'd0, 5'd0, 5'd0);
        Branch_i = 1'b1;
        #1;
        check("x0_ctrl", 32'(ctrl), 32'(C_BR));
        step();
        clear_inputs();
        check("x0_stall_cnt", 32'(stall_cnt_o), 1);
        check("x0_flush_cnt", 32'(flush_cnt_o), 1);

        // three back-to-back branch flushes
        pulse_reset();
        Branch_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("br_ctrl_%0d", i), 32'(ctrl), 32'(C_BR));
            step();
        end
        clear_inputs();
        check("br_flush_cnt", 32'(flush_cnt_o), 3);
        check("br_stall_cnt", 32'(stall_cnt_o), 0);

        // memory wait, ack on the 4th cycle, load-use applied mid-wait
        pulse_reset();
        mem_req_i = 1'b1;
        #1;
        check("mw_c1_ctrl", 32'(ctrl), 32'(C_FRZ));
        step();
        check("mw_state_wait", 32'(dbg_state_o), 1);
        set_loaduse(5'd7, 5'd7, 5'd0);
        #1;
        check("mw_c2_ctrl_lu", 32'(ctrl), 32'(C_FRZ));
        step();
        set_loaduse(5'd0, 5'd0, 5'd0);
        IDEX_MemRead_i = 1'b0;
        #1;
        check("mw_c3_ctrl", 32'(ctrl), 32'(C_FRZ));
        step();
        mem_ack_i = 1'b1;
        #1;
        check("mw_ack_ctrl", 32'(ctrl), 32'(C_RUN));
        step();
        clear_inputs();
        check("mw_state_run", 32'(dbg_state_o), 0);
        check("mw_stall_cnt", 32'(stall_cnt_o), 3);

        // timeout into ERR
        pulse_reset();
        mem_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("to_state_%0d", i), 32'(dbg_state_o), 1);
            check($sformatf("to_err_%0d", i), 32'(err_o), 0);
        end
        step();
        check("to_err_set", 32'(err_o), 1);
        check("to_state_err", 32'(dbg_state_o), 2);
        check("to_ctrl", 32'(ctrl), 32'(C_FRZ));
        mem_ack_i = 1'b1;
        step();
        check("to_ack_ignored", 32'(err_o), 1);
        check("to_stall_cnt5", 32'(stall_cnt_o), 5);
        clear_inputs();
        repeat (3) step();
        check("to_stall_sat", 32'(stall_cnt_o), 7);
        #1;
        check("to_ctrl_idle_in", 32'(ctrl), 32'(C_FRZ));
        start_i = 1'b0;
        #1;
        check("rst_in_err_ctrl", 32'(ctrl), 32'(C_OFF));
        check("rst_in_err_err", 32'(err_o), 0);
        check("rst_in_err_cnt", 32'(stall_cnt_o), 0);
        check("rst_in_err_state", 32'(dbg_state_o), 0);
        start_i = 1'b1;
        #1;
        check("post_err_ctrl", 32'(ctrl), 32'(C_RUN));

        // reset in the middle of a wait discards it
        mem_req_i = 1'b1;
        repeat (2) step();
        check("midwait_state", 32'(dbg_state_o), 1);
        start_i = 1'b0;
        #1;
        check("midwait_rst_state", 32'(dbg_state_o), 0);
        check("midwait_rst_cnt", 32'(stall_cnt_o), 0);
        mem_req_i = 1'b0;
        start_i = 1'b1;
        #1;
        check("midwait_ctrl", 32'(ctrl), 32'(C_RUN));
        step();
        check("midwait_stays_run", 32'(dbg_state_o), 0);

        // saturation of the stall counter on a held load-use
        pulse_reset();
        set_loaduse(5'd9, 5'd9, 5'd3);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 3) check("sat_cnt3", 32'(stall_cnt_o), 3);
            if (i == 7) check("sat_cnt7", 32'(stall_cnt_o), 7);
        end
        check("sat_cnt10", 32'(stall_cnt_o), 7);
        check("sat_ctrl", 32'(ctrl), 32'(C_LU));
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
